// File: rtl/player_scene_engine_pkg.sv
// Shared types and bit indices for the player/scene engine.
// Motion state encoding, key bit positions and probe slice positions.
// No logic; imported by the engine and its sub-modules.
package player_scene_engine_pkg;

    typedef enum logic [1:0] {
        GROUNDED = 2'd0,
        RISING   = 2'd1,
        FALLING  = 2'd2
    } motion_t;

    // key bus bit positions
    localparam int KEY_RIGHT = 3;
    localparam int KEY_LEFT  = 2;
    localparam int KEY_JUMP  = 0;

    // probe / solid slice positions, {up,left,right,down}
    localparam int PROBE_DOWN  = 0;
    localparam int PROBE_RIGHT = 1;
    localparam int PROBE_LEFT  = 2;
    localparam int PROBE_UP    = 3;

endpackage

// File: rtl/player_scene_engine_if.sv
// Bundles the engine's key, lookup, probe and pixel-stream signals.
// master = the engine, slave = the surrounding key/lookup/VGA logic.
// Plain wires; no timing of its own.
interface player_scene_engine_if #(
    parameter int COORD_W  = 9,
    parameter int COLOUR_W = 3
);
    logic [COORD_W-1:0]   max_x;
    logic [COORD_W-1:0]   max_y;
    logic [3:0]           key;
    logic [COORD_W-1:0]   scan_x;
    logic [COORD_W-1:0]   scan_y;
    logic [COLOUR_W-1:0]  bg_colour;
    logic [COLOUR_W-1:0]  spr_colour;
    logic [4*COORD_W-1:0] probe_x;
    logic [4*COORD_W-1:0] probe_y;
    logic [3:0]           solid;
    logic [COORD_W-1:0]   x_out;
    logic [COORD_W-1:0]   y_out;
    logic [COLOUR_W-1:0]  colour_out;
    logic [COORD_W-1:0]   char_x;
    logic [COORD_W-1:0]   char_y;
    logic [1:0]           motion_state;

    modport master (
        input  max_x, max_y, key, bg_colour, spr_colour, solid,
        output scan_x, scan_y, probe_x, probe_y, x_out, y_out, colour_out,
               char_x, char_y, motion_state
    );

    modport slave (
        output max_x, max_y, key, bg_colour, spr_colour, solid,
        input  scan_x, scan_y, probe_x, probe_y, x_out, y_out, colour_out,
               char_x, char_y, motion_state
    );
endinterface

// File: rtl/player_scene_engine_tick_gen.sv
// Physics tick divider: free-running count 0..DIV-1.
// tick is high for the single cycle in which the count wraps.
// No backpressure; always counting.
module player_scene_engine_tick_gen #(
    parameter int DIV = 60
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);
    localparam int CW = $clog2(DIV);

    logic [CW-1:0] count;

    assign tick = (count == CW'(DIV - 1));

    // wrap the count on the tick cycle, otherwise advance
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/player_scene_engine.sv
// Raster-scan compositor plus single-player platform physics.
// Pixel stream has 1 cycle of latency; physics updates once per TICK_DIV cycles.
// No backpressure: scan advances every cycle, lookups must answer in one cycle.
module player_scene_engine
    import player_scene_engine_pkg::*;
#(
    parameter int              COORD_W   = 9,
    parameter int              COLOUR_W  = 3,
    parameter int              TICK_DIV  = 60,
    parameter int              JUMP_H    = 40,
    parameter int              SPRITE_W  = 8,
    parameter int              SPRITE_H  = 12,
    parameter int              START_X   = 35,
    parameter int              START_Y   = 205,
    parameter logic [COLOUR_W-1:0] BG_COLOUR = 3'b001
) (
    input  logic                 clock,
    input  logic                 reset,
    player_scene_engine_if.master bus
);
    localparam logic [COLOUR_W-1:0] TRANSPARENT = '1;
    localparam logic [COLOUR_W-1:0] EMPTY       = '0;
    localparam logic [COORD_W-1:0]  HALF_W      = COORD_W'(SPRITE_W / 2);
    localparam logic [COORD_W-1:0]  FULL_W      = COORD_W'(SPRITE_W);
    localparam logic [COORD_W-1:0]  HALF_H      = COORD_W'(SPRITE_H / 2);
    localparam logic [COORD_W-1:0]  FULL_H      = COORD_W'(SPRITE_H);
    localparam logic [COORD_W-1:0]  RISE        = COORD_W'(JUMP_H);
    // extra headroom so boundary sums never wrap
    localparam int                  EW          = COORD_W + 2;

    logic [COORD_W-1:0]  scan_x, scan_y;
    logic [COORD_W-1:0]  x_out, y_out;
    logic [COLOUR_W-1:0] colour_out;
    logic                tick;

    logic [COORD_W-1:0]  char_x, char_y, apex;
    logic                jump_armed;
    motion_t             state_q, state_d;
    logic [COORD_W-1:0]  x_d, y_d, apex_d;
    logic                armed_d;
    logic [COORD_W-1:0]  x_dec, y_dec, jump_apex;
    logic                room_right, at_floor, go_right, go_left;
    logic                unused_key;

    assign unused_key = bus.key[1];

    player_scene_engine_tick_gen #(.DIV(TICK_DIV)) u_tick_gen (
        .clock (clock),
        .reset (reset),
        .tick  (tick)
    );

    // raster scan: column every cycle, row on column wrap, frame wrap at last row
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scan_x <= '0;
            scan_y <= '0;
        end else if (scan_x == bus.max_x) begin
            scan_x <= '0;
            scan_y <= (scan_y == bus.max_y) ? '0 : scan_y + 1'b1;
        end else begin
            scan_x <= scan_x + 1'b1;
        end
    end

    // compositor: sprite over background over fill colour, one register stage
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x_out      <= '0;
            y_out      <= '0;
            colour_out <= BG_COLOUR;
        end else begin
            x_out <= scan_x;
            y_out <= scan_y;
            if (bus.spr_colour != TRANSPARENT) begin
                colour_out <= bus.spr_colour;
            end else if (bus.bg_colour != EMPTY) begin
                colour_out <= bus.bg_colour;
            end else begin
                colour_out <= BG_COLOUR;
            end
        end
    end

    assign x_dec      = (char_x == '0) ? '0 : char_x - 1'b1;
    assign y_dec      = (char_y == '0) ? '0 : char_y - 1'b1;
    assign jump_apex  = (char_y >= RISE) ? char_y - RISE : '0;
    assign room_right = (EW'(char_x) + EW'(SPRITE_W)) <= EW'(bus.max_x);
    assign at_floor   = (EW'(char_y) + EW'(SPRITE_H)) >  EW'(bus.max_y);

    // collision probe coordinates; they move only when the player moves
    always_comb begin
        bus.probe_x = '0;
        bus.probe_y = '0;
        bus.probe_x[PROBE_DOWN*COORD_W  +: COORD_W] = char_x + HALF_W;
        bus.probe_y[PROBE_DOWN*COORD_W  +: COORD_W] = char_y + FULL_H;
        bus.probe_x[PROBE_RIGHT*COORD_W +: COORD_W] = char_x + FULL_W;
        bus.probe_y[PROBE_RIGHT*COORD_W +: COORD_W] = char_y + HALF_H;
        bus.probe_x[PROBE_LEFT*COORD_W  +: COORD_W] = x_dec;
        bus.probe_y[PROBE_LEFT*COORD_W  +: COORD_W] = char_y + HALF_H;
        bus.probe_x[PROBE_UP*COORD_W    +: COORD_W] = char_x + HALF_W;
        bus.probe_y[PROBE_UP*COORD_W    +: COORD_W] = y_dec;
    end

    assign go_right = bus.key[KEY_RIGHT] && !bus.key[KEY_LEFT] &&
                      !bus.solid[PROBE_RIGHT] && room_right;
    assign go_left  = bus.key[KEY_LEFT] && !bus.key[KEY_RIGHT] &&
                      !bus.solid[PROBE_LEFT] && (char_x != '0);

    // next player position, jump arming and jump FSM state
    always_comb begin
        x_d     = char_x;
        y_d     = char_y;
        state_d = state_q;
        apex_d  = apex;
        armed_d = jump_armed;

        if (go_right) begin
            x_d = char_x + 1'b1;
        end else if (go_left) begin
            x_d = char_x - 1'b1;
        end

        // a release re-arms; the jump itself consumes the arm
        if (bus.key[KEY_JUMP]) begin
            armed_d = 1'b1;
        end

        case (state_q)
            GROUNDED: begin
                if (!bus.solid[PROBE_DOWN]) begin
                    state_d = FALLING;
                end else if (!bus.key[KEY_JUMP] && jump_armed) begin
                    state_d = RISING;
                    apex_d  = jump_apex;
                    armed_d = 1'b0;
                end
            end
            RISING: begin
                if (bus.solid[PROBE_UP] || char_y == apex || char_y == '0) begin
                    state_d = FALLING;
                end else begin
                    y_d = char_y - 1'b1;
                end
            end
            FALLING: begin
                if (bus.solid[PROBE_DOWN] || at_floor) begin
                    state_d = GROUNDED;
                end else begin
                    y_d = char_y + 1'b1;
                end
            end
            default: state_d = FALLING;
        endcase
    end

    // physics state advances only on the tick
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            char_x     <= COORD_W'(START_X);
            char_y     <= COORD_W'(START_Y);
            state_q    <= FALLING;
            apex       <= '0;
            jump_armed <= 1'b0;
        end else if (tick) begin
            char_x     <= x_d;
            char_y     <= y_d;
            state_q    <= state_d;
            apex       <= apex_d;
            jump_armed <= armed_d;
        end
    end

    assign bus.scan_x       = scan_x;
    assign bus.scan_y       = scan_y;
    assign bus.x_out        = x_out;
    assign bus.y_out        = y_out;
    assign bus.colour_out   = colour_out;
    assign bus.char_x       = char_x;
    assign bus.char_y       = char_y;
    assign bus.motion_state = state_q;
endmodule

// File: tb/tb_player_scene_engine.sv
// Bench for player_scene_engine: table vectors for the compositor,
// hand sequences for fall/jump/move/reset, then randomized ticks
// compared against a behavioural model of the physics and scan rules.
module tb_player_scene_engine;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    player_scene_engine_if bus ();

    player_scene_engine dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_cyc, m_sx, m_sy, m_px, m_py;
    int m_x, m_y, m_st, m_apex;
    bit m_armed;
    bit scan_chk_en = 0;

    function automatic int sat_dec(input int v);
        return (v > 0) ? v - 1 : 0;
    endfunction

    task automatic phys_step();
        bit sd, sr, sl, su, kr, kl, kj;
        int nx, ny, nst;
        sd = bus.solid[0]; sr = bus.solid[1]; sl = bus.solid[2]; su = bus.solid[3];
        kr = bus.key[3];   kl = bus.key[2];   kj = bus.key[0];
        nx = m_x; ny = m_y; nst = m_st;
        if (kr && !kl && !sr && m_x < int'(bus.max_x) - 8 + 1) nx = m_x + 1;
        else if (kl && !kr && !sl && m_x > 0)                  nx = m_x - 1;
        if (m_st == 0) begin
            if (!sd) nst = 2;
            else if (!kj && m_armed) begin
                nst = 1;
                m_apex = (m_y - 40 < 0) ? 0 : m_y - 40;
                m_armed = 0;
            end
        end else if (m_st == 1) begin
            if (su || m_y == m_apex || m_y == 0) nst = 2;
            else ny = m_y - 1;
        end else begin
            if (sd || m_y >= int'(bus.max_y) - 12 + 1) nst = 0;
            else ny = m_y + 1;
        end
        if (kj) m_armed = 1;
        m_x = nx; m_y = ny; m_st = nst;
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_cyc = 0; m_sx = 0; m_sy = 0; m_px = 0; m_py = 0;
            m_x = 35; m_y = 205; m_st = 2; m_apex = 0; m_armed = 0;
        end else begin
            m_cyc++;
            m_px = m_sx; m_py = m_sy;
            if (m_sx == int'(bus.max_x)) begin
                m_sx = 0;
                m_sy = (m_sy == int'(bus.max_y)) ? 0 : (m_sy + 1) % 512;
            end else begin
                m_sx = (m_sx + 1) % 512;
            end
            if (m_cyc % 60 == 0) phys_step();
        end
    end

    // scan and pixel-coordinate check at every line start
    always @(negedge clock) begin
        if (scan_chk_en && !reset && m_sx == 0) begin
            check("scan_y@line", int'(bus.scan_y), m_sy);
            check("x_out@line",  int'(bus.x_out),  m_px);
            check("y_out@line",  int'(bus.y_out),  m_py);
        end
    end

    task automatic check_model(input string tag);
        check({tag, ".char_x"}, int'(bus.char_x), m_x);
        check({tag, ".char_y"}, int'(bus.char_y), m_y);
        check({tag, ".state"},  int'(bus.motion_state), m_st);
        check({tag, ".down_x"},  int'(bus.probe_x[8:0]),   (m_x + 4) % 512);
        check({tag, ".down_y"},  int'(bus.probe_y[8:0]),   (m_y + 12) % 512);
        check({tag, ".right_x"}, int'(bus.probe_x[17:9]),  (m_x + 8) % 512);
        check({tag, ".right_y"}, int'(bus.probe_y[17:9]),  (m_y + 6) % 512);
        check({tag, ".left_x"},  int'(bus.probe_x[26:18]), sat_dec(m_x));
        check({tag, ".left_y"},  int'(bus.probe_y[26:18]), (m_y + 6) % 512);
        check({tag, ".up_x"},    int'(bus.probe_x[35:27]), (m_x + 4) % 512);
        check({tag, ".up_y"},    int'(bus.probe_y[35:27]), sat_dec(m_y));
    endtask

    function automatic int composite(input int spr, input int bg);
        if (spr != 7) return spr;
        if (bg != 0)  return bg;
        return 1;
    endfunction

    // ---------------- helpers ----------------
    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic wait_ticks(input int n);
        repeat (60 * n) @(negedge clock);
    endtask

    task automatic wait_scan(input int sx, input int sy, input int budget, input string name);
        int k;
        k = 0;
        while (!(int'(bus.scan_x) == sx && int'(bus.scan_y) == sy) && k < budget) begin
            @(negedge clock);
            k++;
        end
        check({name, ".reached"}, int'(k < budget), 1);
    endtask

    typedef struct {
        logic [2:0] spr;
        logic [2:0] bg;
        logic [2:0] exp;
    } cvec_t;

    initial begin
        cvec_t tbl[7];
        int    nt;
        int    spr_r, bg_r;

        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cvec_t tbl[7];
        int    spr_r, bg_r;

        tbl[0] = '{3'b111, 3'b010, 3'b010};
        tbl[1] = '{3'b100, 3'b010, 3'b100};
        tbl[2] = '{3'b111, 3'b000, 3'b001};
        tbl[3] = '{3'b000, 3'b101, 3'b000};
        tbl[4] = '{3'b111, 3'b111, 3'b111};
        tbl[5] = '{3'b011, 3'b000, 3'b011};
        tbl[6] = '{3'b110, 3'b110, 3'b110};

        reset          = 1'b1;
        bus.max_x      = 9'd319;
        bus.max_y      = 9'd239;
        bus.key        = 4'b0001;
        bus.bg_colour  = 3'b000;
        bus.spr_colour = 3'b111;
        bus.solid      = 4'b0000;

        // 1. reset state, line wrap
        @(negedge clock);
        check("rst.colour_out", int'(bus.colour_out), 1);
        check("rst.scan_x", int'(bus.scan_x), 0);
        check("rst.scan_y", int'(bus.scan_y), 0);
        check("rst.x_out", int'(bus.x_out), 0);
        check("rst.char_x", int'(bus.char_x), 35);
        check("rst.char_y", int'(bus.char_y), 205);
        check("rst.state", int'(bus.motion_state), 2);
        reset = 1'b0;
        scan_chk_en = 1;
        wait_scan(319, 0, 400, "line_wrap");
        @(negedge clock);
        check("line_wrap.scan_x", int'(bus.scan_x), 0);
        check("line_wrap.scan_y", int'(bus.scan_y), 1);

        // 2. compositor table
        for (int i = 0; i < 7; i++) begin
            bus.spr_colour = tbl[i].spr;
            bus.bg_colour  = tbl[i].bg;
            @(negedge clock);
            check($sformatf("comp[%0d]", i), int'(bus.colour_out), int'(tbl[i].exp));
        end
        bus.spr_colour = 3'b111;
        bus.bg_colour  = 3'b000;

        // 3. fall from start, then land
        do_reset();
        bus.key = 4'b0001; bus.solid = 4'b0000;
        repeat (59) @(negedge clock);
        check("fall.pre_tick_y", int'(bus.char_y), 205);
        @(negedge clock);
        check("fall.tick1_y", int'(bus.char_y), 206);
        wait_ticks(1);
        check("fall.tick2_y", int'(bus.char_y), 207);
        check("fall.tick2_state", int'(bus.motion_state), 2);
        bus.solid = 4'b0001;
        wait_ticks(1);
        check("land.state", int'(bus.motion_state), 0);
        check("land.y", int'(bus.char_y), 207);

        // 4. jump from y=205 to apex 165, no re-jump without release
        do_reset();
        bus.solid = 4'b0001; bus.key = 4'b0001;
        wait_ticks(1);
        check("jump.grounded", int'(bus.motion_state), 0);
        bus.key = 4'b0000;
        wait_ticks(1);
        check("jump.start_state", int'(bus.motion_state), 1);
        check("jump.start_y", int'(bus.char_y), 205);
        wait_ticks(40);
        check("jump.apex_y", int'(bus.char_y), 165);
        check("jump.apex_state", int'(bus.motion_state), 1);
        wait_ticks(1);
        check("jump.fall_state", int'(bus.motion_state), 2);
        check("jump.fall_y", int'(bus.char_y), 165);
        wait_ticks(1);
        check("jump.reland", int'(bus.motion_state), 0);
        wait_ticks(3);
        check("jump.no_rejump_state", int'(bus.motion_state), 0);
        check("jump.no_rejump_y", int'(bus.char_y), 165);

        // 5. horizontal moves
        do_reset();
        bus.solid = 4'b0011; bus.key = 4'b1001;
        wait_ticks(2);
        check("move.blocked_x", int'(bus.char_x), 35);
        bus.solid = 4'b0001;
        wait_ticks(1);
        check("move.right1_x", int'(bus.char_x), 36);
        wait_ticks(1);
        check("move.right2_x", int'(bus.char_x), 37);
        bus.key = 4'b1101;
        wait_ticks(2);
        check("move.both_x", int'(bus.char_x), 37);
        bus.key = 4'b0101;
        wait_ticks(1);
        check("move.left_x", int'(bus.char_x), 36);

        // 6. reset mid-jump
        do_reset();
        bus.solid = 4'b0001; bus.key = 4'b0001; bus.spr_colour = 3'b100;
        wait_ticks(1);
        bus.key = 4'b0000;
        wait_ticks(26);
        check("midjump.y", int'(bus.char_y), 180);
        check("midjump.state", int'(bus.motion_state), 1);
        check("midjump.colour", int'(bus.colour_out), 4);
        reset = 1'b1;
        #1;
        check("async_rst.char_x", int'(bus.char_x), 35);
        check("async_rst.char_y", int'(bus.char_y), 205);
        check("async_rst.state", int'(bus.motion_state), 2);
        check("async_rst.colour", int'(bus.colour_out), 1);
        @(negedge clock);
        reset = 1'b0;

        // 7. randomized ticks against the model, narrow screen to hit the right edge
        bus.max_x = 9'd45;
        for (int t = 0; t < 150; t++) begin
            bus.key   = 4'($urandom_range(0, 15));
            bus.solid = {1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                         1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1))};
            spr_r = $urandom_range(0, 7);
            bg_r  = $urandom_range(0, 7);
            bus.spr_colour = 3'(spr_r);
            bus.bg_colour  = 3'(bg_r);
            @(negedge clock);
            check("rand.colour", int'(bus.colour_out), composite(spr_r, bg_r));
            repeat (59) @(negedge clock);
            check_model($sformatf("rand[%0d]", t));
        end

        // 8. full-frame wrap
        bus.max_x = 9'd319;
        bus.max_y = 9'd3;
        bus.spr_colour = 3'b111;
        do_reset();
        wait_scan(319, 3, 2000, "frame_wrap");
        @(negedge clock);
        check("frame_wrap.scan_x", int'(bus.scan_x), 0);
        check("frame_wrap.scan_y", int'(bus.scan_y), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
